// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage types and constants: state encoding, PC width, reset PC and instruction step.
package fetch_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] INSTR_STEP = 32'd4;
    localparam logic [PC_W-1:0] BOOT_ADDR_DEFAULT = 32'h0000_1000;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-cache request bus between the fetch unit (master) and the cache (slave).
interface fetch_pc_unit_if;
    import fetch_pkg::*;

    logic            ic_req_o;
    logic            ic_ready_i;
    logic [PC_W-1:0] ic_data_i;

    modport master (
        output ic_req_o,
        input  ic_ready_i,
        input  ic_data_i
    );

    modport slave (
        input  ic_req_o,
        output ic_ready_i,
        output ic_data_i
    );

endinterface

// File: rtl/fetch_pc_unit_next_pc.sv
// Combinational next-PC logic: sequential/predicted PC after a completed fetch and branch-redirect PC.
// FETCH_DYN_PRED_EN selects dynamic prediction; otherwise static not-taken.
module fetch_next_pc
    import fetch_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] pred_pc_i,
    input  logic            prediction_i,
    input  logic            taken_i,
    input  logic            alu_jumps_i,
    input  logic [PC_W-1:0] alu_target_pc_i,
    input  logic [PC_W-1:0] alu_branch_pc_i,
    output logic [PC_W-1:0] next_pc_o,
    output logic [PC_W-1:0] redirect_pc_o
);

    logic [PC_W-1:0] seqPc;

    assign seqPc = pc_i + INSTR_STEP;

`ifdef FETCH_DYN_PRED_EN
    assign next_pc_o = (prediction_i && taken_i) ? pred_pc_i : seqPc;
`else
    // Predictor lookup is ignored in the static not-taken build.
    logic unusedPred;
    assign unusedPred = ^{pred_pc_i, prediction_i, taken_i};
    assign next_pc_o  = seqPc;
`endif

    assign redirect_pc_o = alu_jumps_i ? alu_target_pc_i : (alu_branch_pc_i + INSTR_STEP);

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: BOOT/FETCH/DRAIN sequencing, I-cache requests and the fetch-to-decode slot.
// Optional FETCH_DYN_PRED_EN enables dynamic branch prediction (default: static not-taken).
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fetch_pc_unit_if.master  ic,
    output logic [PC_W-1:0]  pc_o,
    input  logic [PC_W-1:0]  pred_pc_i,
    input  logic             prediction_i,
    input  logic             taken_i,
    input  logic             bp_error_i,
    input  logic             alu_jumps_i,
    input  logic [PC_W-1:0]  alu_target_pc_i,
    input  logic [PC_W-1:0]  alu_branch_pc_i,
    input  logic             stall_i,
    output logic             if_valid_o,
    output logic [PC_W-1:0]  if_instr_o,
    output logic [PC_W-1:0]  if_pc_o,
    output logic             if_prediction_o,
    output logic             if_taken_o
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] redirPc_q, redirPc_d;
    logic            ifValid_q, ifValid_d;
    logic [PC_W-1:0] ifInstr_q, ifInstr_d;
    logic [PC_W-1:0] ifPc_q, ifPc_d;
    logic            ifPred_q, ifPred_d;
    logic            ifTaken_q, ifTaken_d;
    logic            icReq;
    logic            slotPred;
    logic            slotTaken;
    logic [PC_W-1:0] nextPc;
    logic [PC_W-1:0] redirectPc;

    fetch_next_pc u_next_pc (
        .pc_i            (pc_q),
        .pred_pc_i       (pred_pc_i),
        .prediction_i    (prediction_i),
        .taken_i         (taken_i),
        .alu_jumps_i     (alu_jumps_i),
        .alu_target_pc_i (alu_target_pc_i),
        .alu_branch_pc_i (alu_branch_pc_i),
        .next_pc_o       (nextPc),
        .redirect_pc_o   (redirectPc)
    );

`ifdef FETCH_DYN_PRED_EN
    assign slotPred  = prediction_i;
    assign slotTaken = taken_i;
`else
    assign slotPred  = 1'b0;
    assign slotTaken = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_BOOT;
            pc_q      <= BOOT_ADDR;
            redirPc_q <= '0;
            ifValid_q <= 1'b0;
            ifInstr_q <= '0;
            ifPc_q    <= '0;
            ifPred_q  <= 1'b0;
            ifTaken_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            redirPc_q <= redirPc_d;
            ifValid_q <= ifValid_d;
            ifInstr_q <= ifInstr_d;
            ifPc_q    <= ifPc_d;
            ifPred_q  <= ifPred_d;
            ifTaken_q <= ifTaken_d;
        end
    end

    // A branch error outranks completion and stall; an outstanding request is drained before redirecting.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        redirPc_d = redirPc_q;
        ifValid_d = ifValid_q;
        ifInstr_d = ifInstr_q;
        ifPc_d    = ifPc_q;
        ifPred_d  = ifPred_q;
        ifTaken_d = ifTaken_q;
        icReq     = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                icReq = !ifValid_q || !stall_i;
                if (bp_error_i) begin
                    redirPc_d = redirectPc;
                    ifValid_d = 1'b0;
                    if (icReq && !ic.ic_ready_i) begin
                        state_d = ST_DRAIN;
                    end else begin
                        pc_d = redirectPc;
                    end
                end else if (icReq && ic.ic_ready_i) begin
                    ifValid_d = 1'b1;
                    ifInstr_d = ic.ic_data_i;
                    ifPc_d    = pc_q;
                    ifPred_d  = slotPred;
                    ifTaken_d = slotTaken;
                    pc_d      = nextPc;
                end else if (ifValid_q && !stall_i) begin
                    ifValid_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                icReq = 1'b1;
                if (bp_error_i) begin
                    redirPc_d = redirectPc;
                end
                if (ic.ic_ready_i) begin
                    state_d = ST_FETCH;
                    pc_d    = bp_error_i ? redirectPc : redirPc_q;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign ic.ic_req_o      = icReq;
    assign pc_o             = pc_q;
    assign if_valid_o       = ifValid_q;
    assign if_instr_o       = ifInstr_q;
    assign if_pc_o          = ifPc_q;
    assign if_prediction_o  = ifPred_q;
    assign if_taken_o       = ifTaken_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed testbench for fetch_pc_unit: per-cycle comparison against a behavioural model plus literal checkpoints.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] pc_o;
    logic [31:0] pred_pc_i = '0;
    logic        prediction_i = 1'b0;
    logic        taken_i = 1'b0;
    logic        bp_error_i = 1'b0;
    logic        alu_jumps_i = 1'b0;
    logic [31:0] alu_target_pc_i = '0;
    logic [31:0] alu_branch_pc_i = '0;
    logic        stall_i = 1'b0;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        if_prediction_o;
    logic        if_taken_o;

    int nChecks = 0;
    int nPass   = 0;

    fetch_pc_unit_if icBus ();

    fetch_pc_unit #(.BOOT_ADDR(32'h0000_1000)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .ic              (icBus),
        .pc_o            (pc_o),
        .pred_pc_i       (pred_pc_i),
        .prediction_i    (prediction_i),
        .taken_i         (taken_i),
        .bp_error_i      (bp_error_i),
        .alu_jumps_i     (alu_jumps_i),
        .alu_target_pc_i (alu_target_pc_i),
        .alu_branch_pc_i (alu_branch_pc_i),
        .stall_i         (stall_i),
        .if_valid_o      (if_valid_o),
        .if_instr_o      (if_instr_o),
        .if_pc_o         (if_pc_o),
        .if_prediction_o (if_prediction_o),
        .if_taken_o      (if_taken_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: booting/draining flags, the PC, the pending redirect target and the decode slot.
    logic        mBoot   = 1'b1;
    logic        mDrain  = 1'b0;
    logic [31:0] mPc     = 32'h0000_1000;
    logic [31:0] mRedir  = '0;
    logic        mValid  = 1'b0;
    logic [31:0] mInstr  = '0;
    logic [31:0] mIfPc   = '0;
    logic        mPred   = 1'b0;
    logic        mTaken  = 1'b0;

`ifdef FETCH_DYN_PRED_EN
    localparam bit DYN = 1'b1;
`else
    localparam bit DYN = 1'b0;
`endif

    function automatic logic expReq();
        if (mBoot)  return 1'b0;
        if (mDrain) return 1'b1;
        return !mValid || !stall_i;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst_i) begin
                mBoot = 1'b1; mDrain = 1'b0; mPc = 32'h0000_1000; mRedir = '0;
                mValid = 1'b0; mInstr = '0; mIfPc = '0; mPred = 1'b0; mTaken = 1'b0;
            end else if (mBoot) begin
                mBoot = 1'b0;
            end else begin
                logic        req;
                logic [31:0] tgt;
                req = expReq();
                tgt = alu_jumps_i ? alu_target_pc_i : alu_branch_pc_i + 32'd4;
                if (mDrain) begin
                    if (bp_error_i) mRedir = tgt;
                    if (icBus.ic_ready_i) begin
                        mPc = mRedir;
                        mDrain = 1'b0;
                    end
                end else if (bp_error_i) begin
                    mRedir = tgt;
                    mValid = 1'b0;
                    if (req && !icBus.ic_ready_i) mDrain = 1'b1;
                    else mPc = tgt;
                end else if (req && icBus.ic_ready_i) begin
                    mValid = 1'b1;
                    mInstr = icBus.ic_data_i;
                    mIfPc  = mPc;
                    mPred  = DYN && prediction_i;
                    mTaken = DYN && taken_i;
                    mPc    = (DYN && prediction_i && taken_i) ? pred_pc_i : mPc + 32'd4;
                end else if (mValid && !stall_i) begin
                    mValid = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("cmp.pc", pc_o, mPc);
            checkOutput("cmp.ic_req", {31'd0, icBus.ic_req_o}, {31'd0, expReq()});
            checkOutput("cmp.if_valid", {31'd0, if_valid_o}, {31'd0, mValid});
            if (mValid) begin
                checkOutput("cmp.if_instr", if_instr_o, mInstr);
                checkOutput("cmp.if_pc", if_pc_o, mIfPc);
                checkOutput("cmp.if_pred", {31'd0, if_prediction_o}, {31'd0, mPred});
                checkOutput("cmp.if_taken", {31'd0, if_taken_o}, {31'd0, mTaken});
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic ready, input logic [31:0] data,
                                 input logic stall, input logic bperr);
        rst_i             = rst;
        icBus.ic_ready_i  = ready;
        icBus.ic_data_i   = data;
        stall_i           = stall;
        bp_error_i        = bperr;
        @(negedge clk);
        #1;
    endtask

    logic [31:0] expP;

    initial begin
        icBus.ic_ready_i = 1'b0;
        icBus.ic_data_i  = '0;
        expP = DYN ? 32'h0000_2000 : 32'h0000_100C;

        // Reset with a stray ready that must be ignored
        applyStimulus(1, 1, 32'hDEAD_0000, 0, 0);
        checkOutput("rst.pc", pc_o, 32'h0000_1000);
        checkOutput("rst.req", {31'd0, icBus.ic_req_o}, 32'd0);
        applyStimulus(1, 1, 32'hDEAD_0001, 0, 0);
        applyStimulus(0, 1, 32'h0000_00A0, 0, 0);
        checkOutput("boot.valid", {31'd0, if_valid_o}, 32'd0);
        checkOutput("boot.pc", pc_o, 32'h0000_1000);

        applyStimulus(0, 1, 32'h0000_00A0, 0, 0);
        checkOutput("seq.pc1", pc_o, 32'h0000_1004);
        checkOutput("seq.ifpc0", if_pc_o, 32'h0000_1000);
        applyStimulus(0, 1, 32'h0000_00A1, 0, 0);
        checkOutput("seq.pc2", pc_o, 32'h0000_1008);

        // Predicted-taken lookup at 0x1008
        pred_pc_i = 32'h0000_2000; prediction_i = 1'b1; taken_i = 1'b1;
        applyStimulus(0, 1, 32'h0000_00A2, 0, 0);
        checkOutput("pred.pc", pc_o, expP);
        checkOutput("pred.ifpc", if_pc_o, 32'h0000_1008);
        checkOutput("pred.taken", {31'd0, if_taken_o}, {31'd0, DYN});
        pred_pc_i = '0; prediction_i = 1'b0; taken_i = 1'b0;

        // Mispredict with request outstanding -> drain
        alu_jumps_i = 1'b0; alu_branch_pc_i = 32'h0000_1010;
        applyStimulus(0, 0, 32'h0, 0, 1);
        checkOutput("drain.valid", {31'd0, if_valid_o}, 32'd0);
        checkOutput("drain.pc", pc_o, expP);
        applyStimulus(0, 0, 32'h0, 0, 0);
        checkOutput("drain.req", {31'd0, icBus.ic_req_o}, 32'd1);
        applyStimulus(0, 1, 32'h0000_0BAD, 0, 0);
        checkOutput("drain.redir", pc_o, 32'h0000_1014);
        checkOutput("drain.drop", {31'd0, if_valid_o}, 32'd0);
        applyStimulus(0, 1, 32'h0000_00B0, 0, 0);
        checkOutput("redir.instr", if_instr_o, 32'h0000_00B0);
        checkOutput("redir.ifpc", if_pc_o, 32'h0000_1014);

        // Three-cycle stall holds the slot
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 32'h0000_00B1, 1, 0);
            checkOutput("stall.req", {31'd0, icBus.ic_req_o}, 32'd0);
            checkOutput("stall.instr", if_instr_o, 32'h0000_00B0);
            checkOutput("stall.ifpc", if_pc_o, 32'h0000_1014);
        end
        applyStimulus(0, 1, 32'h0000_00B1, 0, 0);
        checkOutput("unstall.instr", if_instr_o, 32'h0000_00B1);
        checkOutput("unstall.ifpc", if_pc_o, 32'h0000_1018);
        applyStimulus(0, 0, 32'h0, 0, 0);
        checkOutput("consume.valid", {31'd0, if_valid_o}, 32'd0);
        checkOutput("consume.pc", pc_o, 32'h0000_101C);

        // Jump to the top of the address space, then wrap
        alu_jumps_i = 1'b1; alu_target_pc_i = 32'hFFFF_FFFC;
        applyStimulus(0, 1, 32'hDEAD_0002, 0, 1);
        checkOutput("jump.pc", pc_o, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 32'h0000_00C0, 0, 0);
        checkOutput("wrap.pc", pc_o, 32'h0000_0000);
        checkOutput("wrap.ifpc", if_pc_o, 32'hFFFF_FFFC);

        // Reset while draining
        alu_jumps_i = 1'b0; alu_branch_pc_i = 32'h0000_3000;
        applyStimulus(0, 0, 32'h0, 0, 1);
        checkOutput("drain2.req", {31'd0, icBus.ic_req_o}, 32'd1);
        applyStimulus(1, 1, 32'hDEAD_0003, 0, 0);
        checkOutput("rstdrain.pc", pc_o, 32'h0000_1000);
        checkOutput("rstdrain.req", {31'd0, icBus.ic_req_o}, 32'd0);
        checkOutput("rstdrain.valid", {31'd0, if_valid_o}, 32'd0);
        checkOutput("rstdrain.instr", if_instr_o, 32'd0);
        checkOutput("rstdrain.ifpc", if_pc_o, 32'd0);
        checkOutput("rstdrain.taken", {31'd0, if_taken_o}, 32'd0);
        applyStimulus(0, 1, 32'h0000_00EE, 0, 0);
        checkOutput("reboot.valid", {31'd0, if_valid_o}, 32'd0);
        applyStimulus(0, 1, 32'h0000_00D0, 0, 0);
        checkOutput("reboot.pc", pc_o, 32'h0000_1004);
        checkOutput("reboot.instr", if_instr_o, 32'h0000_00D0);

        // Two errors while draining: the last one wins
        alu_branch_pc_i = 32'h0000_4000;
        applyStimulus(0, 0, 32'h0, 0, 1);
        alu_jumps_i = 1'b1; alu_target_pc_i = 32'h0000_5000;
        applyStimulus(0, 0, 32'h0, 0, 1);
        applyStimulus(0, 1, 32'h0000_0BAD, 0, 0);
        checkOutput("lastwins.pc", pc_o, 32'h0000_5000);

        // Error while stalled with no request in flight redirects at once
        applyStimulus(0, 1, 32'h0000_00E0, 0, 0);
        alu_jumps_i = 1'b0; alu_branch_pc_i = 32'h0000_6000;
        applyStimulus(0, 0, 32'h0, 1, 1);
        checkOutput("stallerr.pc", pc_o, 32'h0000_6004);
        checkOutput("stallerr.valid", {31'd0, if_valid_o}, 32'd0);
        applyStimulus(0, 0, 32'h0, 0, 0);
        applyStimulus(0, 1, 32'h0000_00F0, 0, 0);
        checkOutput("final.pc", pc_o, 32'h0000_6008);

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_1000, first fetch PC after reset.
REQ-002 SHALL have ports: clk_i  in  1  clock, all state on rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-high.
REQ-004 pc_o  out  32  current fetch PC, driven to the branch predictor pc_i and the instruction cache.
REQ-005 pred_pc_i  in  32; prediction_i  in  1; taken_i  in  1: predictor lookup result for pc_o.
REQ-006 bp_error_i  in  1; alu_jumps_i  in  1; alu_target_pc_i  in  32; alu_branch_pc_i  in  32: resolved-branch correction from ALU/predictor.
REQ-007 ic_req_o  out  1 fetch request; ic_ready_i  in  1 data returned; ic_data_i  in  32 instruction word.
REQ-008 stall_i  in  1  decode back-pressure.
REQ-009 if_valid_o  out  1; if_instr_o  out  32; if_pc_o  out  32; if_prediction_o  out  1; if_taken_o  out  1: registered fetch-to-decode slot.

Function
REQ-010 SHALL implement FSM states BOOT, FETCH, DRAIN.
REQ-011 BOOT: ic_req_o=0, pc_o=BOOT_ADDR; next cycle -> FETCH.
REQ-012 FETCH: ic_req_o = !if_valid_o | !stall_i (output slot free); pc_o held stable until a request completes.
REQ-013 Request completes in the cycle ic_req_o & ic_ready_i; then slot loads {1, ic_data_i, pc_o, prediction_i, taken_i}.
REQ-014 Next PC on completion: prediction_i & taken_i ? pred_pc_i : pc_o+4, 32-bit wrap-around (32'hFFFF_FFFC+4 = 0).
REQ-015 Redirect PC = alu_jumps_i ? alu_target_pc_i : alu_branch_pc_i+4, latched into redirect register on bp_error_i.
REQ-016 bp_error_i has priority over completion and stall: clears if_valid_o the following cycle; completing data in that cycle discarded.
REQ-017 bp_error_i in FETCH with ic_req_o=1 and ic_ready_i=0 -> DRAIN; else pc_o = redirect PC next cycle, stay FETCH.
REQ-018 DRAIN: ic_req_o=1 with old pc_o regardless of stall_i; on ic_ready_i data discarded, pc_o = redirect PC, -> FETCH.
REQ-019 Further bp_error_i in DRAIN overwrites redirect register; last error wins.
REQ-020 Slot consumed when if_valid_o & !stall_i; if no new completion that cycle, if_valid_o->0.
REQ-021 stall_i with if_valid_o=1 SHALL hold all if_* outputs unchanged.
REQ-022 Fetch latency: ic_ready_i in cycle N -> if_valid_o in cycle N+1.

Reset
REQ-023 rst_i=1 at any clock edge, including mid-request or DRAIN, SHALL force state=BOOT, pc_o=BOOT_ADDR, ic_req_o=0, if_valid_o=0, if_instr_o=0, if_pc_o=0, if_prediction_o=0, if_taken_o=0, redirect register=0.
REQ-024 ic_ready_i arriving during reset or BOOT SHALL be ignored.

Configuration
REQ-025 Macro FETCH_DYN_PRED_EN: defined -> REQ-014 as written.
REQ-026 Not defined -> static not-taken: next PC always pc_o+4, if_prediction_o=0, if_taken_o=0; pred_pc_i, prediction_i, taken_i unused; redirect via bp_error_i unchanged.

Structure
REQ-027 Shared package (fetch_pkg) SHALL hold fetch state enum, BOOT_ADDR default, PC width constant (32), instruction step constant (4).
REQ-028 One combinational sub-module fetch_next_pc SHALL compute sequential/predicted/redirect PC; FSM and registers stay in fetch_pc_unit.

Verification
REQ-029 Reset release, BOOT_ADDR=0x1000, ic_ready_i each request -> pc_o 0x1000,0x1004,0x1008; if_pc_o lags one cycle.
REQ-030 FETCH_DYN_PRED_EN, pc_o=0x1008, prediction_i=1, taken_i=1, pred_pc_i=0x2000 -> next pc_o=0x2000, if_taken_o=1 with if_pc_o=0x1008.
REQ-031 bp_error_i, alu_jumps_i=0, alu_branch_pc_i=0x1010, request outstanding -> DRAIN, returned word dropped, then pc_o=0x1014, if_valid_o=0 meanwhile.
REQ-032 stall_i=1 for 3 cycles with if_valid_o=1 -> ic_req_o=0, if_* stable; stall_i=0 -> next word accepted, no instruction lost or duplicated.
REQ-033 rst_i asserted while in DRAIN -> next cycle BOOT, all outputs at reset values, pc_o=0x1000.
REQ-034 pc_o=0xFFFF_FFFC, not taken -> next pc_o=0x0000_0000.
